// File: rtl/rng_sampler.sv
// rtl/rng_sampler.sv - uniform value sampler built from a serial LFSR bit stream
//
// Assembles WIDTH serial LFSR bits (first bit lands in the MSB) into a word and
// returns it when it is below LIMIT. Words at or above LIMIT are rejected and
// resampled. After MAX_RETRY rejections the sampler returns 0 with fallback=1.
// An all-zero LFSR state seen while shifting latches lock_err. While lock_err
// is set, further requests are refused until reset.
//
// Optional macro RNG_SAMPLER_STATS_EN adds reject_cnt, a saturating count of
// rejected words.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   rand_bit   LFSR feedback bit, one new bit per clock
//   lfsr_state current LFSR state, watched for lock-up while shifting
//   req        sample request, taken only while ready=1
//   ack        consumer accepts value, taken only while valid=1
//   ready      sampler idle and able to take req
//   value      sampled value, stable while valid=1
//   valid      value available, held until ack
//   fallback   value is the fallback 0 because the retry budget ran out
//   lock_err   sticky: LFSR seen at 4'b0000 during sampling
//   reject_cnt (RNG_SAMPLER_STATS_EN only) saturating rejected-word count
module rng_sampler #(
  parameter int WIDTH     = 8,
  parameter int LIMIT     = 160,
  parameter int MAX_RETRY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rand_bit,
  input  logic [3:0]       lfsr_state,
  input  logic             req,
  input  logic             ack,
  output logic             ready,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             fallback,
  output logic             lock_err
`ifdef RNG_SAMPLER_STATS_EN
  ,
  output logic [15:0]      reject_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK, S_HOLD} state_t;

  localparam int             BCW      = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  // One extra bit so LIMIT == 2^WIDTH is representable and always passes.
  localparam logic [WIDTH:0] LIMIT_X  = (WIDTH + 1)'(LIMIT);
  localparam logic [3:0]     LAST_TRY = 4'(MAX_RETRY - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [3:0]         retry_cnt_q, retry_cnt_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic               valid_q, valid_d;
  logic               fallback_q, fallback_d;
  logic               lock_err_q, lock_err_d;
`ifdef RNG_SAMPLER_STATS_EN
  logic [15:0]        reject_cnt_q, reject_cnt_d;
`endif

  logic word_ok;
  logic lock_seen;
  logic start;

  assign word_ok   = ({1'b0, sr_q} < LIMIT_X);
  assign lock_seen = (lfsr_state == 4'b0000);
  assign start     = req && !lock_err_q;

  // State register and datapath flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      retry_cnt_q  <= '0;
      value_q      <= '0;
      valid_q      <= 1'b0;
      fallback_q   <= 1'b0;
      lock_err_q   <= 1'b0;
`ifdef RNG_SAMPLER_STATS_EN
      reject_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      value_q      <= value_d;
      valid_q      <= valid_d;
      fallback_q   <= fallback_d;
      lock_err_q   <= lock_err_d;
`ifdef RNG_SAMPLER_STATS_EN
      reject_cnt_q <= reject_cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: begin
        if (lock_seen)                  state_d = S_IDLE;
        else if (bit_cnt_q == LAST_BIT) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (word_ok || retry_cnt_q == LAST_TRY) state_d = S_HOLD;
        else                                    state_d = S_SHIFT;
      end
      S_HOLD:  if (ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    value_d      = value_q;
    valid_d      = valid_q;
    fallback_d   = fallback_q;
    lock_err_d   = lock_err_q;
`ifdef RNG_SAMPLER_STATS_EN
    reject_cnt_d = reject_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bit_cnt_d   = '0;
          retry_cnt_d = '0;
        end
      end
      S_SHIFT: begin
        // Lock-up aborts the sample; the partial word is simply abandoned.
        if (lock_seen) begin
          lock_err_d = 1'b1;
        end else begin
          sr_d      = {sr_q[WIDTH-2:0], rand_bit};
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      S_CHECK: begin
        if (word_ok) begin
          value_d    = sr_q;
          fallback_d = 1'b0;
          valid_d    = 1'b1;
        end else begin
`ifdef RNG_SAMPLER_STATS_EN
          if (reject_cnt_q != 16'hFFFF) reject_cnt_d = reject_cnt_q + 16'd1;
`endif
          if (retry_cnt_q == LAST_TRY) begin
            value_d    = '0;
            fallback_d = 1'b1;
            valid_d    = 1'b1;
          end else begin
            retry_cnt_d = retry_cnt_q + 4'd1;
            bit_cnt_d   = '0;
          end
        end
      end
      S_HOLD: begin
        if (ack) begin
          valid_d    = 1'b0;
          fallback_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    ready = (state_q == S_IDLE);
  end

  assign value    = value_q;
  assign valid    = valid_q;
  assign fallback = fallback_q;
  assign lock_err = lock_err_q;
`ifdef RNG_SAMPLER_STATS_EN
  assign reject_cnt = reject_cnt_q;
`endif

endmodule

// File: doc/rng_sampler.md
Name: rng_sampler

Overview:
- Consumes the serial feedback bit of the 4-bit LFSR. Assembles WIDTH bits into a word and returns a uniform value in [0, LIMIT) to the game logic (asteroid spawn X/Y, heading).
- Uses rejection sampling with a bounded retry count.
- Watches the LFSR state for the all-zero lock-up condition.
- Sits between the LFSR and the asteroid spawn controller.

Parameters:
- WIDTH, 8, bits per sample word; 2..16.
- LIMIT, 160, exclusive upper bound of the output range; 1 <= LIMIT <= 2^WIDTH.
- MAX_RETRY, 4, rejected words allowed before the fallback value is output; 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rand_bit  input  1  LFSR feedback bit; new bit every clk.
- lfsr_state  input  4  current LFSR state, used for lock-up detection.
- req  input  1  request one sample; sampled only when ready=1.
- ack  input  1  consumer accepts value; meaningful only while valid=1.
- ready  output  1  FSM in IDLE and able to accept req.
- value  output  WIDTH  sampled value, stable while valid=1.
- valid  output  1  value available; held until ack.
- fallback  output  1  qualifies value: retry budget was exhausted; valid with value.
- lock_err  output  1  sticky flag: LFSR seen at 4'b0000 during sampling.

Behaviour:
- Reset: clk and rst are one clock; rst is asynchronous, active-low.
  - State returns to IDLE.
  - Outputs: ready=1, valid=0, value=0, fallback=0, lock_err=0.
  - Internal shift register, bit counter and retry counter cleared.
  - Reset mid-operation aborts any sample in flight; no valid is produced.
- FSM states: IDLE, SHIFT, CHECK, HOLD.
- IDLE: ready=1. If req=1 and lock_err=0 at an edge, go to SHIFT and clear the bit count and retry count. If req=1 and lock_err=1, the request is ignored and the FSM stays in IDLE.
- SHIFT: ready=0.
  - Each edge: sr <= {sr[WIDTH-2:0], rand_bit}, bit_cnt++. The first captured bit ends up as MSB.
  - After WIDTH bits have been captured, go to CHECK.
- CHECK (one cycle), unsigned compare:
  - sr < LIMIT: value <= sr, fallback <= 0, valid <= 1, go to HOLD.
  - Else if retry_cnt+1 == MAX_RETRY: value <= 0, fallback <= 1, valid <= 1, go to HOLD.
  - Else: retry_cnt++, clear bit_cnt, return to SHIFT.
- HOLD: valid=1; value and fallback stay stable. ack=1 at an edge clears valid and fallback and returns to IDLE, so ready=1 the next cycle. Without ack, the FSM holds indefinitely.
- Latency: req accepted at edge E0 → bits captured at E1..E_WIDTH → valid high after edge E_(WIDTH+1). Each rejection adds WIDTH+1 cycles.
  - Worst case is MAX_RETRY*(WIDTH+1) cycles.
  - Minimum req-to-req throughput is WIDTH+3 cycles (includes ack and return to IDLE).
- req outside IDLE is ignored. ack outside HOLD is ignored.
- Lock-up detection:
  - If lfsr_state == 4'b0000 at any edge while in SHIFT, set lock_err=1 (sticky until rst) and abort to IDLE with valid=0.
  - lfsr_state is not checked in IDLE, CHECK or HOLD.
- LIMIT == 2^WIDTH: the compare always passes and there are no rejections.

Optional Feature:
- Macro: RNG_SAMPLER_STATS_EN.
- Defined:
  - Adds output reject_cnt (16 bits): count of rejected words.
  - Incremented in CHECK on each rejection, including the final rejection that triggers fallback.
  - Saturates at 16'hFFFF; cleared only by rst.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
1. Reset/idle: rst=0 mid-SHIFT, then release → valid=0, ready=1, value=0, lock_err=0; no spurious valid within 20 cycles.
2. Accept path (WIDTH=8, LIMIT=160): req, then drive rand_bit 1,0,0,1,0,1,1,0 → value=8'h96 (150), fallback=0, valid rises 9 cycles after the req edge; hold ack=0 for 5 cycles → value stable; ack → ready=1 the next cycle.
3. Single rejection: drive bits 11110000 (240≥160, rejected), then 00001010 → value=10, valid 18 cycles after req, reject_cnt=1 when RNG_SAMPLER_STATS_EN is defined.
4. Fallback: drive all-ones for 4 words (MAX_RETRY=4) → value=0, fallback=1, valid 36 cycles after req, reject_cnt=4.
5. Lock-up: lfsr_state=4'b0000 during the 3rd SHIFT cycle → lock_err=1, state IDLE, valid never asserts; a subsequent req is ignored until rst.
6. Handshake misuse: req pulsed during SHIFT and ack pulsed in IDLE → no effect; exactly one valid per accepted req.
